// File: rtl/rvhs_pkg.sv
// Shared definitions for the ready/valid handshake stages (master, skid buffer, slave).
`timescale 1ns/1ps
package rvhs_pkg;

  // Default payload width used by every stage on the handshake chain.
  localparam int DATA_W_DEF = 8;

  // Occupancy states of the skid buffer; encoding 2'd3 is unused and illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/rv_skid_buffer.sv
// Two-entry ready/valid register slice. s_ready, m_valid and m_data all come
// straight from flops, so no combinational path crosses the slice. The main
// register always holds the oldest beat; the skid register catches the one
// beat that arrives in the cycle the downstream side stalls.
`timescale 1ns/1ps
module rv_skid_buffer
  import rvhs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  beat_cnt
);

  state_t              state_reg, state_next;
  logic                s_ready_reg, s_ready_next;
  logic                m_valid_reg, m_valid_next;
  logic [DATA_W-1:0]   main_reg, main_next;
  logic [DATA_W-1:0]   skid_reg, skid_next;
  logic [CNT_W-1:0]    beat_cnt_reg;

  logic                accept;
  logic                deliver;

  // Handshakes are qualified by the registered ready/valid, never by inputs alone.
  assign accept  = s_valid && s_ready_reg;
  assign deliver = m_valid_reg && m_ready;

  // State, flag and datapath registers; reset empties the buffer and drops held beats.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_reg   <= EMPTY;
      s_ready_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      main_reg    <= '0;
      skid_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      s_ready_reg <= s_ready_next;
      m_valid_reg <= m_valid_next;
      main_reg    <= main_next;
      skid_reg    <= skid_next;
    end
  end

  // Next-state and next-register values for each occupancy state.
  always_comb begin
    state_next   = state_reg;
    s_ready_next = s_ready_reg;
    m_valid_next = m_valid_reg;
    main_next    = main_reg;
    skid_next    = skid_reg;

    case (state_reg)
      EMPTY: begin
        // s_ready is low only on the first cycle out of reset; raise it here.
        s_ready_next = 1'b1;
        if (accept) begin
          main_next    = s_data;
          m_valid_next = 1'b1;
          state_next   = BUSY;
        end
      end

      BUSY: begin
        if (accept && !deliver) begin
          // Downstream stalled: park the new beat behind the main one.
          skid_next    = s_data;
          s_ready_next = 1'b0;
          state_next   = FULL;
        end else if (deliver && !accept) begin
          m_valid_next = 1'b0;
          state_next   = EMPTY;
        end else if (accept && deliver) begin
          // Pass-through at full rate: replace the beat just delivered.
          main_next = s_data;
        end
      end

      FULL: begin
        if (deliver) begin
          // Skid beat is next in line; promote it and reopen the input.
          main_next    = skid_reg;
          s_ready_next = 1'b1;
          state_next   = BUSY;
        end
      end

      default: begin
        // Unused encoding: fall back to an empty buffer with reset outputs.
        state_next   = EMPTY;
        s_ready_next = 1'b0;
        m_valid_next = 1'b0;
        main_next    = '0;
        skid_next    = '0;
      end
    endcase
  end

  // Delivered-beat counter; wraps modulo 2^CNT_W.
  always_ff @(posedge aclk) begin
    if (rst) begin
      beat_cnt_reg <= '0;
    end else if (deliver) begin
      beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
    end
  end

  assign s_ready  = s_ready_reg;
  assign m_valid  = m_valid_reg;
  assign m_data   = main_reg;
  assign beat_cnt = beat_cnt_reg;

endmodule
